// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS core: FSM states, opcodes and
// the datapath select/ALU encodings used by control, aluControl and datapath.
package mips_pkg;

   typedef enum logic [3:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StMemAdr = 4'd2,
      StMemRd  = 4'd3,
      StMemWb  = 4'd4,
      StMemWr  = 4'd5,
      StRExec  = 4'd6,
      StRWb    = 4'd7,
      StBranch = 4'd8,
      StJump   = 4'd9,
      StIExec  = 4'd10,
      StIWb    = 4'd11,
      StJal    = 4'd12,
      StHalt   = 4'd13
   } state_t;

   // Opcodes (instruction[31:26])
   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpBne   = 6'b000101;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpJal   = 6'b000011;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpAndi  = 6'b001100;
   localparam logic [5:0] OpOri   = 6'b001101;
   localparam logic [5:0] OpSlti  = 6'b001010;

   // ALUOp
   localparam logic [2:0] AluAdd   = 3'b000;
   localparam logic [2:0] AluSub   = 3'b001;
   localparam logic [2:0] AluFunct = 3'b010;
   localparam logic [2:0] AluAnd   = 3'b011;
   localparam logic [2:0] AluOr    = 3'b100;
   localparam logic [2:0] AluSlt   = 3'b101;

   // MemToReg
   localparam logic [1:0] MtrAluOut = 2'b00;
   localparam logic [1:0] MtrMdr    = 2'b01;
   localparam logic [1:0] MtrPc     = 2'b10;

   // RegDst
   localparam logic [1:0] DstRt  = 2'b00;
   localparam logic [1:0] DstRd  = 2'b01;
   localparam logic [1:0] DstR31 = 2'b10;

   // PCSource
   localparam logic [1:0] PcsAlu    = 2'b00;
   localparam logic [1:0] PcsAluOut = 2'b01;
   localparam logic [1:0] PcsJump   = 2'b10;

   // ALUSrcB
   localparam logic [1:0] SrcBReg   = 2'b00;
   localparam logic [1:0] SrcBFour  = 2'b01;
   localparam logic [1:0] SrcBImm   = 2'b10;
   localparam logic [1:0] SrcBImmSh = 2'b11;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       pc_write_cond_ne;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       alu_src_a;
      logic       reg_write;
      logic       ext_zero;
      logic [1:0] mem_to_reg;
      logic [1:0] reg_dst;
      logic [1:0] pc_source;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
   } ctrl_t;

   // State following DECODE for a given opcode; unknown opcodes halt.
   function automatic state_t decode_next(input logic [5:0] op);
      state_t nxt;
      case (op)
         OpRtype:                      nxt = StRExec;
         OpLw, OpSw:                   nxt = StMemAdr;
         OpBeq, OpBne:                 nxt = StBranch;
         OpJ:                          nxt = StJump;
         OpJal:                        nxt = StJal;
         OpAddi, OpAndi, OpOri, OpSlti: nxt = StIExec;
         default:                      nxt = StHalt;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/mips_perf_cnt.sv
// Saturating up-counter used for the control unit's performance counters.
module mips_perf_cnt #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;

   // Count up on inc, stick at all-ones instead of wrapping
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (inc && (count_q != '1)) begin
         count_q <= count_q + W'(1);
      end
   end

   assign count = count_q;

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM with variable-latency memory handshake,
// illegal-opcode halt and saturating cycle/instruction counters.
module mips_mc_ctrl
   import mips_pkg::*;
#(
   parameter int unsigned CNT_W         = 32,
   parameter bit          MEM_HANDSHAKE = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       op,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             PCWriteCondNe,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             ALUSrcA,
   output logic             RegWrite,
   output logic             ExtZero,
   output logic [1:0]       MemToReg,
   output logic [1:0]       RegDst,
   output logic [1:0]       PCSource,
   output logic [1:0]       ALUSrcB,
   output logic [2:0]       ALUOp,
   output logic [3:0]       state,
   output logic             illegal,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] instr_count
);

   state_t     state_q, state_n;
   logic [5:0] op_q;
   logic       illegal_q;
   logic       mr;
   logic       ext_zero_op;
   ctrl_t      ctrl;

   // Legacy memories complete every access in one cycle
   assign mr = MEM_HANDSHAKE ? mem_ready : 1'b1;

   // andi/ori zero-extend their immediate
   assign ext_zero_op = (op_q == OpAndi) || (op_q == OpOri);

   // Next-state selection; op is only consulted in DECODE, later states use the latched copy
   always_comb begin
      state_n = state_q;
      case (state_q)
         StFetch:  if (mr) state_n = StDecode;
         StDecode: state_n = decode_next(op);
         StMemAdr: state_n = (op_q == OpLw) ? StMemRd : StMemWr;
         StMemRd:  if (mr) state_n = StMemWb;
         StMemWr:  if (mr) state_n = StFetch;
         StRExec:  state_n = StRWb;
         StIExec:  state_n = StIWb;
         StMemWb, StRWb, StBranch, StJump, StJal, StIWb: state_n = StFetch;
         default:  state_n = StHalt;
      endcase
   end

   // State, latched opcode and sticky illegal flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StFetch;
         op_q      <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_n;
         if (state_q == StDecode) op_q <= op;
         if (state_n == StHalt) illegal_q <= 1'b1;
      end
   end

   // Moore control decode; FETCH write strobes wait for mem_ready, reset forces everything low
   always_comb begin
      ctrl = '0;
      case (state_q)
         StFetch: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SrcBFour;
            ctrl.alu_op    = AluAdd;
            ctrl.pc_source = PcsAlu;
            ctrl.ir_write  = mr;
            ctrl.pc_write  = mr;
         end
         StDecode: begin
            ctrl.alu_src_b = SrcBImmSh;
            ctrl.alu_op    = AluAdd;
         end
         StMemAdr: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SrcBImm;
            ctrl.alu_op    = AluAdd;
         end
         StMemRd: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         StMemWb: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = DstRt;
            ctrl.mem_to_reg = MtrMdr;
         end
         StMemWr: begin
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = 1'b1;
         end
         StRExec: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SrcBReg;
            ctrl.alu_op    = AluFunct;
         end
         StRWb: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = DstRd;
            ctrl.mem_to_reg = MtrAluOut;
         end
         StBranch: begin
            ctrl.alu_src_a        = 1'b1;
            ctrl.alu_src_b        = SrcBReg;
            ctrl.alu_op           = AluSub;
            ctrl.pc_source        = PcsAluOut;
            ctrl.pc_write_cond    = (op_q == OpBeq);
            ctrl.pc_write_cond_ne = (op_q == OpBne);
         end
         StJump: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PcsJump;
         end
         StJal: begin
            // PC still holds PC+4 here, so it is written to r31 before the jump lands
            ctrl.pc_write   = 1'b1;
            ctrl.pc_source  = PcsJump;
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = DstR31;
            ctrl.mem_to_reg = MtrPc;
         end
         StIExec: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SrcBImm;
            ctrl.ext_zero  = ext_zero_op;
            case (op_q)
               OpAndi:  ctrl.alu_op = AluAnd;
               OpOri:   ctrl.alu_op = AluOr;
               OpSlti:  ctrl.alu_op = AluSlt;
               default: ctrl.alu_op = AluAdd;
            endcase
         end
         StIWb: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = DstRt;
            ctrl.mem_to_reg = MtrAluOut;
            ctrl.ext_zero   = ext_zero_op;
         end
         default: ctrl = '0;
      endcase
      if (rst) ctrl = '0;
   end

   assign PCWrite       = ctrl.pc_write;
   assign PCWriteCond   = ctrl.pc_write_cond;
   assign PCWriteCondNe = ctrl.pc_write_cond_ne;
   assign IorD          = ctrl.i_or_d;
   assign MemRead       = ctrl.mem_read;
   assign MemWrite      = ctrl.mem_write;
   assign IRWrite       = ctrl.ir_write;
   assign ALUSrcA       = ctrl.alu_src_a;
   assign RegWrite      = ctrl.reg_write;
   assign ExtZero       = ctrl.ext_zero;
   assign MemToReg      = ctrl.mem_to_reg;
   assign RegDst        = ctrl.reg_dst;
   assign PCSource      = ctrl.pc_source;
   assign ALUSrcB       = ctrl.alu_src_b;
   assign ALUOp         = ctrl.alu_op;
   assign state         = state_q;
   assign illegal       = illegal_q;

   logic cyc_inc, ins_inc;
   assign cyc_inc = (state_q != StHalt);
   // An instruction retires whenever the FSM returns to FETCH
   assign ins_inc = (state_q != StFetch) && (state_n == StFetch);

   mips_perf_cnt #(.W(CNT_W)) u_cycle_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (cyc_inc),
      .count (cycle_count)
   );

   mips_perf_cnt #(.W(CNT_W)) u_instr_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (ins_inc),
      .count (instr_count)
   );

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl: a spec-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mips_mc_ctrl;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       pc_write_cond_ne;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       alu_src_a;
      logic       reg_write;
      logic       ext_zero;
      logic [1:0] mem_to_reg;
      logic [1:0] reg_dst;
      logic [1:0] pc_source;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
   } ctl_t;

   localparam logic [31:0] MAXC = 32'hFFFF_FFFF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main DUT: 32-bit counters, handshake honoured
   logic        rst, mem_ready;
   logic [5:0]  op;
   logic        PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite;
   logic        ALUSrcA, RegWrite, ExtZero, illegal;
   logic [1:0]  MemToReg, RegDst, PCSource, ALUSrcB;
   logic [2:0]  ALUOp;
   logic [3:0]  state;
   logic [31:0] cycle_count, instr_count;
   ctl_t        act;

   assign act = {PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite,
                 ALUSrcA, RegWrite, ExtZero, MemToReg, RegDst, PCSource, ALUSrcB, ALUOp};

   mips_mc_ctrl #(.CNT_W(32), .MEM_HANDSHAKE(1'b1)) dut (
      .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteCondNe(PCWriteCondNe),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .ExtZero(ExtZero), .MemToReg(MemToReg),
      .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .state(state), .illegal(illegal), .cycle_count(cycle_count), .instr_count(instr_count)
   );

   // Second DUT: 4-bit counters, legacy single-cycle memory (mem_ready ignored)
   logic        rst_b, mr_b;
   logic [5:0]  op_b;
   logic        b_pcw, b_pcwc, b_pcwcn, b_iord, b_mrd, b_mwr, b_irw, b_asa, b_rw, b_ez, b_ill;
   logic [1:0]  b_mtr, b_rd, b_pcs, b_asb;
   logic [2:0]  b_aluop;
   logic [3:0]  b_state, b_cyc, b_ins;

   mips_mc_ctrl #(.CNT_W(4), .MEM_HANDSHAKE(1'b0)) dut_b (
      .clk(clk), .rst(rst_b), .op(op_b), .mem_ready(mr_b),
      .PCWrite(b_pcw), .PCWriteCond(b_pcwc), .PCWriteCondNe(b_pcwcn),
      .IorD(b_iord), .MemRead(b_mrd), .MemWrite(b_mwr), .IRWrite(b_irw),
      .ALUSrcA(b_asa), .RegWrite(b_rw), .ExtZero(b_ez), .MemToReg(b_mtr),
      .RegDst(b_rd), .PCSource(b_pcs), .ALUSrcB(b_asb), .ALUOp(b_aluop),
      .state(b_state), .illegal(b_ill), .cycle_count(b_cyc), .instr_count(b_ins)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   // ---------------- spec-level model of the main DUT ----------------
   int          m_state;
   logic [5:0]  m_op;
   logic        m_ill;
   logic [31:0] m_cyc, m_ins;
   logic        m_valid = 1'b0;
   int          m_nxt;

   function automatic int model_next(int s, logic [5:0] opi, logic [5:0] lat, logic mr);
      case (s)
         0: return mr ? 1 : 0;
         1: begin
            case (opi)
               6'd0:                     return 6;
               6'd35, 6'd43:             return 2;
               6'd4, 6'd5:               return 8;
               6'd2:                     return 9;
               6'd3:                     return 12;
               6'd8, 6'd12, 6'd13, 6'd10: return 10;
               default:                  return 13;
            endcase
         end
         2:          return (lat == 6'd35) ? 3 : 5;
         3:          return mr ? 4 : 3;
         5:          return mr ? 0 : 5;
         6:          return 7;
         10:         return 11;
         4, 7, 8, 9, 11, 12: return 0;
         default:    return 13;
      endcase
   endfunction

   function automatic ctl_t model_ctrl(int s, logic [5:0] lat, logic mr, logic r);
      ctl_t e = '0;
      if (r) return e;
      case (s)
         0:  begin e.mem_read = 1; e.alu_src_b = 2'd1; e.ir_write = mr; e.pc_write = mr; end
         1:  e.alu_src_b = 2'd3;
         2:  begin e.alu_src_a = 1; e.alu_src_b = 2'd2; end
         3:  begin e.mem_read = 1; e.i_or_d = 1; end
         4:  begin e.reg_write = 1; e.mem_to_reg = 2'd1; end
         5:  begin e.mem_write = 1; e.i_or_d = 1; end
         6:  begin e.alu_src_a = 1; e.alu_op = 3'd2; end
         7:  begin e.reg_write = 1; e.reg_dst = 2'd1; end
         8:  begin
            e.alu_src_a = 1; e.alu_op = 3'd1; e.pc_source = 2'd1;
            e.pc_write_cond = (lat == 6'd4); e.pc_write_cond_ne = (lat == 6'd5);
         end
         9:  begin e.pc_write = 1; e.pc_source = 2'd2; end
         10: begin
            e.alu_src_a = 1; e.alu_src_b = 2'd2;
            e.alu_op   = (lat == 6'd12) ? 3'd3 : (lat == 6'd13) ? 3'd4 :
                         (lat == 6'd10) ? 3'd5 : 3'd0;
            e.ext_zero = (lat == 6'd12) || (lat == 6'd13);
         end
         11: begin e.reg_write = 1; e.ext_zero = (lat == 6'd12) || (lat == 6'd13); end
         12: begin
            e.pc_write = 1; e.pc_source = 2'd2; e.reg_write = 1;
            e.reg_dst = 2'd2; e.mem_to_reg = 2'd2;
         end
         default: ;
      endcase
      return e;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_state <= 0;
         m_ill   <= 1'b0;
         m_cyc   <= '0;
         m_ins   <= '0;
         m_op    <= '0;
         m_valid <= 1'b1;
      end else if (m_valid) begin
         m_nxt = model_next(m_state, op, m_op, mem_ready);
         if (m_state != 13 && m_cyc != MAXC) m_cyc <= m_cyc + 1;
         if (m_state != 0 && m_nxt == 0 && m_ins != MAXC) m_ins <= m_ins + 1;
         if (m_nxt == 13) m_ill <= 1'b1;
         if (m_state == 1) m_op <= op;
         m_state <= m_nxt;
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (m_valid) begin
         check("ctrl", 64'(act), 64'(model_ctrl(m_state, m_op, mem_ready, rst)));
         check("state", 64'(state), 64'(m_state));
         check("illegal", 64'(illegal), 64'(m_ill));
         check("cycle_count", 64'(cycle_count), 64'(m_cyc));
         check("instr_count", 64'(instr_count), 64'(m_ins));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   ctl_t snap [16];
   int   st_seq [$];
   int   ir_pulses, pcw_pulses, rw_cycles, mw_cycles;
   logic rd_ok;

   // Runs one instruction from FETCH with fw FETCH wait cycles and mw memory wait cycles.
   // Drives garbage on op outside DECODE. Ends at the next FETCH, at HALT, or on timeout.
   task automatic run_instr(input logic [5:0] opc, input int fw, input int mw, output int cycles);
      int   fl = fw;
      int   ml = mw;
      int   cur;
      logic left = 1'b0;
      for (int i = 0; i < 16; i++) snap[i] = '0;
      st_seq.delete();
      ir_pulses = 0; pcw_pulses = 0; rw_cycles = 0; mw_cycles = 0; rd_ok = 1'b1;
      cycles = 0;
      do begin
         cur = m_state;
         if (cur != 0) left = 1'b1;
         op = (cur == 1) ? opc : 6'h3f;
         if (cur == 0) begin
            mem_ready = (fl == 0);
            if (fl > 0) fl--;
         end else if (cur == 3 || cur == 5) begin
            mem_ready = (ml == 0);
            if (ml > 0) ml--;
         end else begin
            mem_ready = 1'($urandom_range(0, 1));
         end
         #3;
         st_seq.push_back(int'(state));
         snap[cur] = act;
         if (act.ir_write) ir_pulses++;
         if (act.pc_write) pcw_pulses++;
         if (act.reg_write) rw_cycles++;
         if (cur == 5 && act.mem_write) mw_cycles++;
         if ((cur == 0 || cur == 3) && !act.mem_read) rd_ok = 1'b0;
         cycles++;
         tick();
      end while (!(left && m_state == 0) && m_state != 13 && cycles < 40);
      if (cycles >= 40) check("instr_timeout", 64'(cycles), 64'(0));
   endtask

   int   n;
   int   frozen;
   int   bad;

   initial begin
      rst = 1'b1; op = 6'd0; mem_ready = 1'b1;
      rst_b = 1'b1; op_b = 6'd0; mr_b = 1'b0;

      // Reset held two cycles; second cycle shows FETCH with every strobe forced low
      tick();
      #2;
      check("rst_state", 64'(state), 64'(0));
      check("rst_ctrl_forced", 64'(act), 64'(0));
      check("rst_cycle_count", 64'(cycle_count), 64'(0));
      check("rst_instr_count", 64'(instr_count), 64'(0));
      tick();
      rst = 1'b0;

      // R-type: FETCH, DECODE, R_EXEC, R_WB, back to FETCH
      run_instr(6'd0, 0, 0, n);
      check("r_cycles", 64'(n), 64'(4));
      check("r_seq0", 64'(st_seq[0]), 64'(0));
      check("r_seq1", 64'(st_seq[1]), 64'(1));
      check("r_seq2", 64'(st_seq[2]), 64'(6));
      check("r_seq3", 64'(st_seq[3]), 64'(7));
      check("r_regwrite_once", 64'(rw_cycles), 64'(1));
      check("r_wb_regdst", 64'({snap[7].reg_write, snap[7].reg_dst}), 64'(3'b101));
      mem_ready = 1'b0;
      #2;
      check("r_back_fetch", 64'(state), 64'(0));
      check("r_instr_count", 64'(instr_count), 64'(1));
      check("r_cycle_count", 64'(cycle_count), 64'(4));
      tick();

      // lw: 3 FETCH waits + 2 MEM_RD waits -> 4+1+1+3+1 cycles
      run_instr(6'd35, 3, 2, n);
      check("lw_cycles", 64'(n), 64'(10));
      check("lw_irwrite_once", 64'(ir_pulses), 64'(1));
      check("lw_pcwrite_once", 64'(pcw_pulses), 64'(1));
      check("lw_memread_waits", 64'(rd_ok), 64'(1));
      check("lw_wb", 64'({snap[4].reg_write, snap[4].reg_dst, snap[4].mem_to_reg}), 64'(5'b10001));

      // sw with 2 MEM_WR waits: MemWrite held for all 3 MEM_WR cycles
      run_instr(6'd43, 0, 2, n);
      check("sw_cycles", 64'(n), 64'(6));
      check("sw_memwrite_hold", 64'(mw_cycles), 64'(3));

      // bne / beq
      run_instr(6'd5, 0, 0, n);
      check("bne_cycles", 64'(n), 64'(3));
      check("bne_condne", 64'(snap[8].pc_write_cond_ne), 64'(1));
      check("bne_cond", 64'(snap[8].pc_write_cond), 64'(0));
      check("bne_aluop", 64'(snap[8].alu_op), 64'(3'b001));
      check("bne_pcsource", 64'(snap[8].pc_source), 64'(2'b01));
      run_instr(6'd4, 0, 0, n);
      check("beq_cond", 64'({snap[8].pc_write_cond, snap[8].pc_write_cond_ne}), 64'(2'b10));

      // jal / j
      run_instr(6'd3, 0, 0, n);
      check("jal_cycles", 64'(n), 64'(3));
      check("jal_regdst", 64'(snap[12].reg_dst), 64'(2'b10));
      check("jal_memtoreg", 64'(snap[12].mem_to_reg), 64'(2'b10));
      check("jal_pcwrite_regwrite", 64'({snap[12].pc_write, snap[12].reg_write}), 64'(2'b11));
      run_instr(6'd2, 0, 0, n);
      check("j_cycles", 64'(n), 64'(3));
      check("j_pcsource", 64'({snap[9].pc_write, snap[9].pc_source}), 64'(3'b110));

      // I-type ALU ops and immediate extension
      run_instr(6'd12, 0, 0, n);
      check("andi_cycles", 64'(n), 64'(4));
      check("andi_aluop", 64'(snap[10].alu_op), 64'(3'b011));
      check("andi_extzero", 64'({snap[10].ext_zero, snap[11].ext_zero}), 64'(2'b11));
      run_instr(6'd8, 0, 0, n);
      check("addi_aluop_ext", 64'({snap[10].alu_op, snap[10].ext_zero}), 64'(4'b0000));
      run_instr(6'd13, 0, 0, n);
      check("ori_aluop_ext", 64'({snap[10].alu_op, snap[10].ext_zero}), 64'(4'b1001));
      run_instr(6'd10, 0, 0, n);
      check("slti_aluop_ext", 64'({snap[10].alu_op, snap[10].ext_zero}), 64'(4'b1010));

      // Illegal opcode: HALT, sticky flag, frozen counter, silent for 20 cycles
      run_instr(6'h3f, 0, 0, n);
      check("halt_cycles", 64'(n), 64'(2));
      #2;
      check("halt_state", 64'(state), 64'(13));
      check("halt_illegal", 64'(illegal), 64'(1));
      frozen = int'(cycle_count);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         op = 6'(i);
         mem_ready = 1'($urandom_range(0, 1));
         tick();
         #2;
         if (act != '0 || state != 4'd13) bad++;
      end
      check("halt_silent", 64'(bad), 64'(0));
      check("halt_cycle_frozen", 64'(cycle_count), 64'(frozen));

      // Reset out of HALT
      rst = 1'b1;
      tick();
      #2;
      check("unhalt_state", 64'(state), 64'(0));
      check("unhalt_illegal", 64'(illegal), 64'(0));
      check("unhalt_counts", 64'({cycle_count, instr_count}), 64'(0));
      check("unhalt_ctrl_forced", 64'(act), 64'(0));
      rst = 1'b0;
      mem_ready = 1'b0;
      tick();

      // Reset while sw waits in MEM_WR: strobe drops immediately, FETCH next
      n = 0;
      while (m_state != 5 && n < 10) begin
         op = (m_state == 1) ? 6'd43 : 6'h3f;
         mem_ready = 1'b1;
         tick();
         n++;
      end
      check("reach_memwr", 64'(m_state), 64'(5));
      mem_ready = 1'b0;
      #1;
      check("memwr_wait_high", 64'(MemWrite), 64'(1));
      rst = 1'b1;
      #1;
      check("rst_memwr_low", 64'(MemWrite), 64'(0));
      tick();
      #1;
      check("rst_memwr_fetch", 64'(state), 64'(0));

      // Legacy memory + 4-bit counters on the second instance; main DUT held in reset
      rst_b = 1'b1;
      tick();
      tick();
      rst_b = 1'b0;
      op_b = 6'd0;
      mr_b = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      #1;
      check("legacy_r_latency", 64'({b_state, b_ins}), 64'({4'd0, 4'd1}));
      check("legacy_cycles", 64'(b_cyc), 64'(4));
      for (int i = 0; i < 76; i++) tick();
      #1;
      check("sat_instr_count", 64'(b_ins), 64'(15));
      check("sat_cycle_count", 64'(b_cyc), 64'(15));
      check("sat_state", 64'(b_state), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
